// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Scheduler for the IF/ID and ID/EX stage registers. It detects load-use
//   hazards and jr redirects, and sequences the stalls, bubbles and flushes
//   they need. While data memory is busy it freezes the whole front end.
//
//   Optional feature macro: STALL_STATS_EN
//     defined   -> stall_cycles / flush_count are saturating counters.
//     undefined -> both ports are tied to 0 and no counter logic is built.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt          source fields of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   ex_dmem_alu           EX instruction is a load
//   ex_reg_wen            EX instruction writes the register file
//   ex_reg_des            EX destination select (1 = rd, 0 = rt)
//   ex_rt, ex_rd          EX register fields
//   ex_jr                 jr resolved in EX this cycle
//   mem_busy              data memory not ready; freeze pipe
//   pc_en, ifid_en        PC / IF/ID load enables
//   ifid_flush            IF/ID clear to NOP
//   idex_en, idex_flush   ID/EX load enable / clear to bubble
//   stall_cycles          cycles with pc_en = 0
//   flush_count           jr flushes taken
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_dmem_alu,
    input  logic              ex_reg_wen,
    input  logic              ex_reg_des,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_jr,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT  = 3'(LOAD_LAT - 1);
    localparam bit         MULTI_LAT = (LOAD_LAT > 1);

    state_t            r_state, r_saved;
    logic [2:0]        r_cnt;

    state_t            w_nxt_state, w_nxt_saved, w_eff;
    logic [2:0]        w_nxt_cnt;
    logic [REG_AW-1:0] w_ex_dest;
    logic              w_lu;
    logic              w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;

    assign w_ex_dest = ex_reg_des ? ex_rd : ex_rt;
    assign w_lu      = ex_dmem_alu & ex_reg_wen & (w_ex_dest != '0) &
                       ((w_ex_dest == id_rs) | (id_uses_rt & (w_ex_dest == id_rt)));

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_saved <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_nxt_state;
            r_saved <= w_nxt_saved;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_saved  = r_saved;
        w_nxt_cnt    = r_cnt;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_en    = 1'b1;
        w_idex_flush = 1'b0;

        // Leaving MEM_WAIT behaves exactly like the state that was frozen,
        // so the pending bubble count resumes where it stopped.
        w_eff = (r_state == S_MEM_WAIT) ? r_saved : r_state;

        if (mem_busy) begin
            w_pc_en     = 1'b0;
            w_ifid_en   = 1'b0;
            w_idex_en   = 1'b0;
            w_nxt_state = S_MEM_WAIT;
            if (r_state != S_MEM_WAIT)
                w_nxt_saved = r_state;
        end else begin
            case (w_eff)
                S_LOAD_STALL: begin
                    // EX holds a bubble here, so jr cannot be resolving
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                    w_nxt_cnt    = r_cnt - 3'd1;
                    w_nxt_state  = (r_cnt == 3'd1) ? S_RUN : S_LOAD_STALL;
                end
                default: begin
                    w_nxt_state = S_RUN;
                    if (ex_jr) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_nxt_cnt    = CNT_INIT;
                        w_nxt_state  = MULTI_LAT ? S_LOAD_STALL : S_RUN;
                    end
                end
            endcase
        end
    end

    // While reset is held the pipe free-runs with no flushes.
    assign pc_en      = ~rst | w_pc_en;
    assign ifid_en    = ~rst | w_ifid_en;
    assign idex_en    = ~rst | w_idex_en;
    assign ifid_flush =  rst & w_ifid_flush;
    assign idex_flush =  rst & w_idex_flush;

`ifdef STALL_STATS_EN
    logic [STAT_W-1:0] r_stall_cycles, r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_ifid_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two controllers (LOAD_LAT = 1 and 3) share one stimulus stream and are
// compared every cycle against a pending-bubble model; directed sequences
// also pin specific cycles to hand-computed output values.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_rt, ex_rd;
    logic          id_uses_rt, ex_dmem_alu, ex_reg_wen, ex_reg_des, ex_jr, mem_busy;

    logic [1:0]    pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
    logic [SW-1:0] stall_o [2];
    logic [SW-1:0] flush_o [2];

    pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .STAT_W(SW)) u_d1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dmem_alu(ex_dmem_alu), .ex_reg_wen(ex_reg_wen), .ex_reg_des(ex_reg_des),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_jr(ex_jr), .mem_busy(mem_busy),
        .pc_en(pc_en_o[0]), .ifid_en(ifid_en_o[0]), .ifid_flush(ifid_flush_o[0]),
        .idex_en(idex_en_o[0]), .idex_flush(idex_flush_o[0]),
        .stall_cycles(stall_o[0]), .flush_count(flush_o[0]));

    pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .STAT_W(SW)) u_d3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dmem_alu(ex_dmem_alu), .ex_reg_wen(ex_reg_wen), .ex_reg_des(ex_reg_des),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_jr(ex_jr), .mem_busy(mem_busy),
        .pc_en(pc_en_o[1]), .ifid_en(ifid_en_o[1]), .ifid_flush(ifid_flush_o[1]),
        .idex_en(idex_en_o[1]), .idex_flush(idex_flush_o[1]),
        .stall_cycles(stall_o[1]), .flush_count(flush_o[1]));

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int lat   [2] = '{1, 3};
    int pend  [2] = '{0, 0};   // bubbles still owed after the current cycle
    int s_cnt [2] = '{0, 0};
    int f_cnt [2] = '{0, 0};

    function automatic bit lu_now();
        logic [AW-1:0] d;
        d = ex_reg_des ? ex_rd : ex_rt;
        return ex_dmem_alu && ex_reg_wen && d != 0 &&
               (d == id_rs || (id_uses_rt && d == id_rt));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
    function automatic logic [4:0] exp_vec(int i);
        if (!rst)          return 5'b11010;
        else if (mem_busy) return 5'b00000;
        else if (pend[i] > 0) return 5'b00011;
        else if (ex_jr)    return 5'b11111;
        else if (lu_now()) return 5'b00011;
        else               return 5'b11010;
    endfunction

    function automatic logic [4:0] dut_vec(int i);
        return {pc_en_o[i], ifid_en_o[i], ifid_flush_o[i], idex_en_o[i], idex_flush_o[i]};
    endfunction

    always @(negedge clk) begin : cmp
        logic [4:0] e;
        int es, ef;
        for (int i = 0; i < 2; i++) begin
            e = exp_vec(i);
            n_chk++;
            if (dut_vec(i) !== e) begin
                n_err++;
                $display("FAIL outs[d%0d] t=%0t got=%b exp=%b", lat[i], $time, dut_vec(i), e);
            end
`ifdef STALL_STATS_EN
            es = rst ? s_cnt[i] : 0;
            ef = rst ? f_cnt[i] : 0;
`else
            es = 0;
            ef = 0;
`endif
            n_chk++;
            if (int'(stall_o[i]) != es || int'(flush_o[i]) != ef) begin
                n_err++;
                $display("FAIL stats[d%0d] t=%0t got=%0d/%0d exp=%0d/%0d",
                         lat[i], $time, stall_o[i], flush_o[i], es, ef);
            end
            // advance model across the coming rising edge
            if (!rst) begin
                pend[i] = 0; s_cnt[i] = 0; f_cnt[i] = 0;
            end else begin
                if (!e[4] && s_cnt[i] < 65535) s_cnt[i]++;
                if (e[2]  && f_cnt[i] < 65535) f_cnt[i]++;
                if (!mem_busy) begin
                    if (pend[i] > 0)       pend[i]--;
                    else if (ex_jr)        pend[i] = pend[i];
                    else if (lu_now())     pend[i] = lat[i] - 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_dmem_alu = 0; ex_reg_wen = 0;
        ex_reg_des = 0; ex_rt = 0; ex_rd = 0; ex_jr = 0; mem_busy = 0;
    endtask

    task automatic lu_pat();
        clr();
        ex_dmem_alu = 1; ex_reg_wen = 1; ex_reg_des = 0; ex_rt = 5; id_rs = 5;
    endtask

    task automatic lit(string nm, int i, logic [4:0] exp);
        n_chk++;
        if (dut_vec(i) !== exp) begin
            n_err++;
            $display("FAIL %s d%0d got=%b exp=%b", nm, lat[i], dut_vec(i), exp);
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin go(); clr(); end
    endtask

    initial begin
        rst = 1'b0;
        clr();
        smp(); lit("reset", 1, 5'b11010); lit("reset", 0, 5'b11010);
        go(); rst = 1'b1;
        smp(); lit("run_idle", 1, 5'b11010);

        // load-use: LAT=1 one bubble, LAT=3 three bubbles
        go(); lu_pat(); smp(); lit("t1_bub", 0, 5'b00011); lit("t2_bub1", 1, 5'b00011);
        go(); clr();    smp(); lit("t1_run", 0, 5'b11010); lit("t2_bub2", 1, 5'b00011);
        go();           smp(); lit("t2_bub3", 1, 5'b00011);
        go();           smp(); lit("t2_run", 1, 5'b11010);

        // jr wins over simultaneous load-use
        go(); lu_pat(); ex_jr = 1; smp(); lit("t3_jr", 0, 5'b11111); lit("t3_jr", 1, 5'b11111);
        go(); clr();    smp(); lit("t3_after", 0, 5'b11010); lit("t3_after", 1, 5'b11010);

        // freeze after the 2nd bubble, then one remaining bubble
        go(); lu_pat(); smp(); lit("t4_bub1", 1, 5'b00011);
        go(); clr();    smp(); lit("t4_bub2", 1, 5'b00011);
        for (int k = 0; k < 4; k++) begin
            go(); mem_busy = 1; smp(); lit("t4_frz", 1, 5'b00000);
        end
        go(); mem_busy = 0; smp(); lit("t4_bub3", 1, 5'b00011);
        go();               smp(); lit("t4_run", 1, 5'b11010);

        // qualifiers that must suppress the stall
        go(); clr(); ex_dmem_alu = 1; ex_reg_wen = 1; smp(); lit("t5_dest0", 0, 5'b11010);
        go(); ex_rt = 5; id_rs = 5; ex_reg_wen = 0;    smp(); lit("t5_nowen", 0, 5'b11010);
        go(); ex_reg_wen = 1; id_rs = 3; id_rt = 5;     smp(); lit("t5_rt_unused", 0, 5'b11010);
        go(); id_uses_rt = 1;                          smp(); lit("t5_rt_used", 0, 5'b00011);
        go(); clr(); ex_dmem_alu = 1; ex_reg_wen = 1; ex_reg_des = 1; ex_rd = 7; id_rs = 7;
        smp(); lit("t5_rd_sel", 1, 5'b00011);
        idle(3);

        // reset in the middle of a stall
        go(); lu_pat(); smp();
        go(); clr();    smp(); lit("t6_stall", 1, 5'b00011);
        go(); rst = 0;  smp(); lit("t6_rst", 1, 5'b11010);
        n_chk++;
        if (stall_o[1] != 0 || flush_o[1] != 0) begin
            n_err++;
            $display("FAIL t6_stats got=%0d/%0d exp=0/0", stall_o[1], flush_o[1]);
        end
        go(); rst = 1;  smp(); lit("t6_run", 1, 5'b11010);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            go();
            rst         = ($urandom_range(0, 199) != 0);
            id_rs       = AW'($urandom_range(0, 3));
            id_rt       = AW'($urandom_range(0, 3));
            ex_rt       = AW'($urandom_range(0, 3));
            ex_rd       = AW'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_dmem_alu = ($urandom_range(0, 2) != 0);
            ex_reg_wen  = ($urandom_range(0, 3) != 0);
            ex_reg_des  = 1'($urandom_range(0, 1));
            ex_jr       = ($urandom_range(0, 9) == 0);
            mem_busy    = ($urandom_range(0, 7) == 0);
        end
        go(); clr(); rst = 1;
        smp();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
